// File: rtl/harris_pkg.sv
`default_nettype none
// ============================================================================
// Package     : harris_pkg
// Description : Shared types and constants for the gradient-window front end
//               of the Harris corner pipeline: sample width, window size,
//               window-generator state and the 4x4 gradient window type.
// Revision    : 1.0 - initial release
// ============================================================================
package harris_pkg;

  // Default gradient sample width (two's complement).
  localparam int DATA_W = 16;

  // Window edge length. Three line buffers plus the live row make a 4-row window.
  localparam int WIN_SZ = 4;

  // Window generator state: FILL while fewer than three full rows are buffered.
  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } grad_state_t;

  // 4x4 gradient window, [row i][column j], index 0 is the oldest sample.
  typedef logic [0:WIN_SZ-1][0:WIN_SZ-1][DATA_W-1:0] grad_win_t;

  // Modulo-3 add used to rotate the three line-buffer roles.
  function automatic logic [1:0] buf_sel_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end
    return s[1:0];
  endfunction

endpackage : harris_pkg
`default_nettype wire

// File: rtl/grad_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : grad_line_buf
// Description : One row of {gx,gy} gradient pairs. Single write port, single
//               asynchronous read port. A read of the address being written in
//               the same cycle returns the previous contents, which is what
//               the window generator relies on to fetch the row three lines up
//               before overwriting it with the current row.
//               Contents are intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module grad_line_buf #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 64,
  parameter int AW     = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [2*DATA_W-1:0]   wdata,
  input  logic [AW-1:0]         raddr,
  output logic [2*DATA_W-1:0]   rdata
);

  logic [2*DATA_W-1:0] r_mem [0:IMG_W-1];

  // Store the accepted pixel pair at its column.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Old contents of the column, ahead of any write on this edge.
  assign rdata = r_mem[raddr];

endmodule : grad_line_buf
`default_nettype wire

// File: rtl/grad_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : grad_window_gen
// Description : Builds 4x4 Gx/Gy windows from a raster stream of gradient
//               samples for the Harris score stage. Three rotating line
//               buffers supply rows r-3..r-1 of the current column; a 4x4 shift
//               window advances one column per accepted pixel. A window is
//               presented one cycle after accepting pixel (r,c), r>=3, c>=3,
//               behind a valid/ready handshake with a one-entry output stage.
// Options     : GRAD_WIN_SOF_EN - adds in_sof; an accepted pixel with in_sof=1
//               restarts framing at (0,0).
// Revision    : 1.0 - initial release
// ============================================================================
module grad_window_gen #(
  parameter int DATA_W = harris_pkg::DATA_W,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 48
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DATA_W-1:0] gx_in,
  input  logic [DATA_W-1:0] gy_in,
`ifdef GRAD_WIN_SOF_EN
  input  logic in_sof,
`endif
  output logic [0:harris_pkg::WIN_SZ-1][0:harris_pkg::WIN_SZ-1][DATA_W-1:0] Gx,
  output logic [0:harris_pkg::WIN_SZ-1][0:harris_pkg::WIN_SZ-1][DATA_W-1:0] Gy,
  output logic out_valid,
  input  logic out_ready
);

  import harris_pkg::*;

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_COL_W = $clog2(IMG_W);
  localparam int c_ROW_W = $clog2(IMG_H);
  localparam int c_BUF_W = 2 * DATA_W;
  localparam int c_NBUF  = WIN_SZ - 1;

  localparam logic [c_COL_W-1:0] c_COL_LAST      = c_COL_W'(IMG_W - 1);
  localparam logic [c_ROW_W-1:0] c_ROW_LAST      = c_ROW_W'(IMG_H - 1);
  localparam logic [c_COL_W-1:0] c_COL_FIRST_WIN = c_COL_W'(WIN_SZ - 1);
  // Last row that is still only filling the line buffers.
  localparam logic [c_ROW_W-1:0] c_ROW_LAST_FILL = c_ROW_W'(WIN_SZ - 2);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [c_COL_W-1:0] r_col;
  logic [c_ROW_W-1:0] r_row;
  logic [1:0]         r_sel;     // buffer currently holding row r-3 (and being overwritten)
  grad_state_t        r_state;

  logic               w_accept;
  logic               w_sof;
  logic               w_emit;

  // Effective position of the pixel on the input, after any start-of-frame override.
  logic [c_COL_W-1:0] w_pos_col;
  logic [c_ROW_W-1:0] w_pos_row;
  logic [1:0]         w_pos_sel;
  grad_state_t        w_pos_state;

  logic [c_BUF_W-1:0] w_lb_rdata [c_NBUF];

  logic [0:WIN_SZ-1][DATA_W-1:0]               w_col_gx;
  logic [0:WIN_SZ-1][DATA_W-1:0]               w_col_gy;
  logic [0:WIN_SZ-1][0:WIN_SZ-1][DATA_W-1:0]   r_win_gx;
  logic [0:WIN_SZ-1][0:WIN_SZ-1][DATA_W-1:0]   r_win_gy;
  logic [0:WIN_SZ-1][0:WIN_SZ-1][DATA_W-1:0]   w_shift_gx;
  logic [0:WIN_SZ-1][0:WIN_SZ-1][DATA_W-1:0]   w_shift_gy;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  // The output stage is one entry deep, so input may flow only when that
  // entry is empty or is being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

`ifdef GRAD_WIN_SOF_EN
  assign w_sof = in_sof;
`else
  assign w_sof = 1'b0;
`endif

  // Resolve the position of the incoming pixel; start of frame forces (0,0).
  always_comb begin
    w_pos_col   = r_col;
    w_pos_row   = r_row;
    w_pos_sel   = r_sel;
    w_pos_state = r_state;
    if (w_sof) begin
      w_pos_col   = '0;
      w_pos_row   = '0;
      w_pos_sel   = 2'd0;
      w_pos_state = S_FILL;
    end
  end

  // A window exists only once three rows are buffered and the 4-column span
  // lies entirely inside the current row.
  assign w_emit = w_accept && (w_pos_state == S_RUN) && (w_pos_col >= c_COL_FIRST_WIN);

  // --------------------------------------------------------------------------
  // Position counters and framing state
  // --------------------------------------------------------------------------
  // Advance column/row/buffer rotation and FILL/RUN state on each accepted pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_sel   <= 2'd0;
      r_state <= S_FILL;
    end else if (w_accept) begin
      if (w_pos_col == c_COL_LAST) begin
        r_col <= '0;
        if (w_pos_row == c_ROW_LAST) begin
          // Frame end: restart framing and buffer rotation from scratch.
          r_row   <= '0;
          r_sel   <= 2'd0;
          r_state <= S_FILL;
        end else begin
          r_row <= w_pos_row + 1'b1;
          r_sel <= buf_sel_add(w_pos_sel, 2'd1);
          if (w_pos_row == c_ROW_LAST_FILL) begin
            r_state <= S_RUN;
          end else begin
            r_state <= w_pos_state;
          end
        end
      end else begin
        r_col   <= w_pos_col + 1'b1;
        r_row   <= w_pos_row;
        r_sel   <= w_pos_sel;
        r_state <= w_pos_state;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Line buffers
  // --------------------------------------------------------------------------
  // Buffer w_pos_sel holds row r-3 at this column: read it, then overwrite
  // it with the current pixel on the same edge.
  for (genvar b = 0; b < c_NBUF; b++) begin : g_lbuf
    grad_line_buf #(
      .DATA_W (DATA_W),
      .IMG_W  (IMG_W),
      .AW     (c_COL_W)
    ) u_lbuf (
      .clk   (clk),
      .we    (w_accept && (w_pos_sel == 2'(b))),
      .waddr (w_pos_col),
      .wdata ({gx_in, gy_in}),
      .raddr (w_pos_col),
      .rdata (w_lb_rdata[b])
    );
  end

  // Assemble the new window column: rows r-3, r-2, r-1 from the rotated
  // buffers, row r straight from the input.
  always_comb begin
    w_col_gx = '0;
    w_col_gy = '0;
    for (int i = 0; i < c_NBUF; i++) begin
      w_col_gx[i] = w_lb_rdata[buf_sel_add(w_pos_sel, 2'(i))][c_BUF_W-1:DATA_W];
      w_col_gy[i] = w_lb_rdata[buf_sel_add(w_pos_sel, 2'(i))][DATA_W-1:0];
    end
    w_col_gx[WIN_SZ-1] = gx_in;
    w_col_gy[WIN_SZ-1] = gy_in;
  end

  // --------------------------------------------------------------------------
  // Shift window
  // --------------------------------------------------------------------------
  // Next window: drop the oldest column, append the new one on the right.
  always_comb begin
    w_shift_gx = r_win_gx;
    w_shift_gy = r_win_gy;
    for (int i = 0; i < WIN_SZ; i++) begin
      for (int j = 0; j < WIN_SZ - 1; j++) begin
        w_shift_gx[i][j] = r_win_gx[i][j+1];
        w_shift_gy[i][j] = r_win_gy[i][j+1];
      end
      w_shift_gx[i][WIN_SZ-1] = w_col_gx[i];
      w_shift_gy[i][WIN_SZ-1] = w_col_gy[i];
    end
  end

  // Window registers track the stream on every accept, emitted or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_gx <= '0;
      r_win_gy <= '0;
    end else if (w_accept) begin
      r_win_gx <= w_shift_gx;
      r_win_gy <= w_shift_gy;
    end
  end

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  // Load a completed window; otherwise hold until downstream takes it. A take
  // and a load on the same edge replace the window without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Gx        <= '0;
      Gy        <= '0;
    end else if (w_emit) begin
      out_valid <= 1'b1;
      Gx        <= w_shift_gx;
      Gy        <= w_shift_gy;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : grad_window_gen
`default_nettype wire

// File: tb/tb_grad_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_grad_window_gen
// Description : Directed self-checking bench for grad_window_gen with an
//               8x6 image. Pixel (r,c) carries gx = base + 16*r + c, gy = -gx,
//               so every window element is known from its position alone.
//               The in_sof scenario is built only with GRAD_WIN_SOF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grad_window_gen;

  localparam int DW = 16;
  localparam int IW = 8;
  localparam int IH = 6;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic [DW-1:0] gx_in;
  logic [DW-1:0] gy_in;
  logic in_sof;
  logic [0:3][0:3][DW-1:0] Gx;
  logic [0:3][0:3][DW-1:0] Gy;
  logic out_valid;
  logic out_ready;

  int n_cmp;
  int n_fail;
  int tr;   // bench's own idea of the next pixel's row
  int tc;   // and column

  grad_window_gen #(
    .DATA_W (DW),
    .IMG_W  (IW),
    .IMG_H  (IH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .gx_in     (gx_in),
    .gy_in     (gy_in),
`ifdef GRAD_WIN_SOF_EN
    .in_sof    (in_sof),
`endif
    .Gx        (Gx),
    .Gy        (Gy),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges the sequence.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Window for pixel (r,c): element [i][j] comes from pixel (r-3+i, c-3+j).
  function automatic bit win_ok(input int r, input int c, input int base);
    logic [DW-1:0] e;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        e = 16'(base + 16 * (r - 3 + i) + (c - 3 + j));
        if (Gx[i][j] !== e || Gy[i][j] !== (16'h0000 - e)) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  // Offer pixel (tr,tc) until accepted (bounded); returns at posedge+1.
  task automatic push_next(input int base, output bit ok);
    gx_in    = 16'(base + 16 * tr + tc);
    gy_in    = 16'h0000 - gx_in;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (ok) begin
      if (tc == IW - 1) begin
        tc = 0;
        tr = (tr == IH - 1) ? 0 : tr + 1;
      end else begin
        tc = tc + 1;
      end
    end
  endtask

  // Stream npix pixels, optionally with random idle gaps, and tally windows
  // seen, windows that are wrong/missing/unexpected, and the first window index.
  task automatic stream(input int npix, input int base, input int gap_pct,
                        output int nwin, output int nbad, output int first_k);
    int r;
    int c;
    bit ok;
    nwin    = 0;
    nbad    = 0;
    first_k = -1;
    for (int k = 0; k < npix; k++) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        repeat ($urandom_range(3, 1)) begin
          @(posedge clk);
          #1;
        end
      end
      r = tr;
      c = tc;
      push_next(base, ok);
      if (!ok) begin
        nbad++;
      end else if (out_valid === 1'b1) begin
        nwin++;
        if (first_k < 0) first_k = k;
        if (!(r >= 3 && c >= 3) || !win_ok(r, c, base)) nbad++;
      end else if (r >= 3 && c >= 3) begin
        nbad++;
      end
    end
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b1;
    gx_in     = '0;
    gy_in     = '0;
    tr        = 0;
    tc        = 0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1;  // before any clock edge: reset must act asynchronously
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (Gx[0][0] !== 16'h0000) begin n_fail++; $display("FAIL reset_gx00: got %h want 0000", Gx[0][0]); end
    n_cmp++; if (Gx[3][3] !== 16'h0000) begin n_fail++; $display("FAIL reset_gx33: got %h want 0000", Gx[3][3]); end
    n_cmp++; if (Gy[3][3] !== 16'h0000) begin n_fail++; $display("FAIL reset_gy33: got %h want 0000", Gy[3][3]); end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_frame();
    int nw1, nb1, fk1, nw2, nb2, fk2;
    stream(28, 0, 0, nw1, nb1, fk1);
    n_cmp++; if (fk1 !== 27) begin n_fail++; $display("FAIL frame_first_window: got pixel %0d want 27", fk1); end
    n_cmp++; if (Gx[0][0] !== 16'h0000) begin n_fail++; $display("FAIL frame_gx00: got %h want 0000", Gx[0][0]); end
    n_cmp++; if (Gx[3][3] !== 16'h0033) begin n_fail++; $display("FAIL frame_gx33: got %h want 0033", Gx[3][3]); end
    n_cmp++; if (Gy[3][3] !== 16'hFFCD) begin n_fail++; $display("FAIL frame_gy33: got %h want FFCD", Gy[3][3]); end
    stream(20, 0, 0, nw2, nb2, fk2);
    n_cmp++; if (nw1 + nw2 !== 15) begin n_fail++; $display("FAIL frame_count: got %0d want 15", nw1 + nw2); end
    n_cmp++; if (nb1 + nb2 !== 0) begin n_fail++; $display("FAIL frame_content: got %0d bad windows want 0", nb1 + nb2); end
  endtask

  task automatic test_no_wrap();
    int nw, nb, fk;
    bit ok;
    stream(32, 0, 0, nw, nb, fk);
    n_cmp++; if (nw !== 5 || nb !== 0) begin n_fail++; $display("FAIL nowrap_rows0to3: got %0d windows %0d bad want 5 / 0", nw, nb); end
    for (int c = 0; c < 3; c++) begin
      push_next(0, ok);
      n_cmp++; if (!ok || out_valid !== 1'b0) begin n_fail++; $display("FAIL nowrap_col%0d: got accepted=%b out_valid=%b want 1 / 0", c, ok, out_valid); end
    end
    push_next(0, ok);
    n_cmp++; if (!ok || out_valid !== 1'b1) begin n_fail++; $display("FAIL nowrap_col3_valid: got accepted=%b out_valid=%b want 1 / 1", ok, out_valid); end
    n_cmp++; if (Gx[0][0] !== 16'h0010) begin n_fail++; $display("FAIL nowrap_gx00: got %h want 0010", Gx[0][0]); end
    n_cmp++; if (Gx[3][3] !== 16'h0043) begin n_fail++; $display("FAIL nowrap_gx33: got %h want 0043", Gx[3][3]); end
    stream(12, 0, 0, nw, nb, fk);
    n_cmp++; if (nw !== 9 || nb !== 0) begin n_fail++; $display("FAIL nowrap_tail: got %0d windows %0d bad want 9 / 0", nw, nb); end
  endtask

  task automatic test_backpressure();
    int nw, nb, fk;
    int stall_bad;
    bit ok;
    stream(28, 0, 0, nw, nb, fk);
    n_cmp++; if (fk !== 27 || nb !== 0) begin n_fail++; $display("FAIL bp_first: got pixel %0d bad %0d want 27 / 0", fk, nb); end
    // Stall with pixel (3,4) waiting on the input.
    out_ready = 1'b0;
    gx_in     = 16'(16 * 3 + 4);
    gy_in     = 16'h0000 - gx_in;
    in_valid  = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      stall_bad = 0;
      if (in_ready !== 1'b0) stall_bad++;
      if (out_valid !== 1'b1) stall_bad++;
      if (!win_ok(3, 3, 0)) stall_bad++;
      n_cmp++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_hold_cycle%0d: got in_ready=%b out_valid=%b gx33=%h want 0 / 1 / 0033", k, in_ready, out_valid, Gx[3][3]); end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    push_next(0, ok);
    n_cmp++; if (!ok || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release: got accepted=%b out_valid=%b want 1 / 1", ok, out_valid); end
    n_cmp++; if (!win_ok(3, 4, 0)) begin n_fail++; $display("FAIL bp_next_window: got gx00=%h gx33=%h want 0001 / 0034", Gx[0][0], Gx[3][3]); end
    stream(19, 0, 0, nw, nb, fk);
    n_cmp++; if (nw !== 13 || nb !== 0) begin n_fail++; $display("FAIL bp_tail: got %0d windows %0d bad want 13 / 0", nw, nb); end
  endtask

  task automatic test_reset_midframe();
    int nw, nb, fk;
    stream(36, 0, 0, nw, nb, fk);
    n_cmp++; if (nw !== 6 || out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got %0d windows out_valid=%b want 6 / 1", nw, out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (Gx[3][3] !== 16'h0000) begin n_fail++; $display("FAIL rstmid_gx33: got %h want 0000", Gx[3][3]); end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    tr = 0;
    tc = 0;
    stream(48, 16'h0200, 0, nw, nb, fk);
    n_cmp++; if (fk !== 27) begin n_fail++; $display("FAIL rstmid_first: got pixel %0d want 27", fk); end
    n_cmp++; if (nw !== 15 || nb !== 0) begin n_fail++; $display("FAIL rstmid_frame: got %0d windows %0d bad want 15 / 0", nw, nb); end
  endtask

  task automatic test_gaps();
    int nw, nb, fk;
    stream(2 * IW * IH, 16'h0300, 50, nw, nb, fk);
    n_cmp++; if (nw !== 30) begin n_fail++; $display("FAIL gaps_count: got %0d want 30", nw); end
    n_cmp++; if (nb !== 0) begin n_fail++; $display("FAIL gaps_content: got %0d bad windows want 0", nb); end
  endtask

`ifdef GRAD_WIN_SOF_EN
  task automatic test_sof();
    int nw, nb, fk;
    int base2;
    bit ok;
    stream(21, 16'h0500, 0, nw, nb, fk);
    n_cmp++; if (nw !== 0) begin n_fail++; $display("FAIL sof_pre: got %0d windows want 0", nw); end
    // Pixel (2,5) carries in_sof: from here on it is (0,0) of a new frame.
    base2  = 16'h0500 + 16 * 2 + 5;
    tr     = 0;
    tc     = 0;
    in_sof = 1'b1;
    push_next(base2, ok);
    in_sof = 1'b0;
    n_cmp++; if (!ok || out_valid !== 1'b0) begin n_fail++; $display("FAIL sof_pixel: got accepted=%b out_valid=%b want 1 / 0", ok, out_valid); end
    stream(26, base2, 0, nw, nb, fk);
    n_cmp++; if (nw !== 0) begin n_fail++; $display("FAIL sof_quiet: got %0d windows want 0", nw); end
    push_next(base2, ok);
    n_cmp++; if (!ok || out_valid !== 1'b1) begin n_fail++; $display("FAIL sof_first_valid: got accepted=%b out_valid=%b want 1 / 1", ok, out_valid); end
    n_cmp++; if (Gx[0][0] !== 16'h0525) begin n_fail++; $display("FAIL sof_gx00: got %h want 0525", Gx[0][0]); end
    stream(20, base2, 0, nw, nb, fk);
    n_cmp++; if (nw !== 14 || nb !== 0) begin n_fail++; $display("FAIL sof_tail: got %0d windows %0d bad want 14 / 0", nw, nb); end
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_frame();
    test_no_wrap();
    test_backpressure();
    test_reset_midframe();
    test_gaps();
`ifdef GRAD_WIN_SOF_EN
    test_sof();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_grad_window_gen
`default_nettype wire
